// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide units: operand magnitudes, init pulse,
// fixed-latency wait, sign correction and HI/LO ownership. Optional abort input: `MULDIV_ABORT_EN.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 33,
  parameter int DIV_CYCLES  = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic [1:0]  op_sel,
  input  logic [31:0] value_A,
  input  logic [31:0] value_B,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
`ifdef MULDIV_ABORT_EN
  input  logic        abort,
`endif
  output logic        mult_init,
  output logic        div_init,
  output logic [31:0] unit_A,
  output logic [31:0] unit_B,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FIXUP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          div_reg, div_next;
  logic          sign_a_reg, sign_a_next;
  logic          sign_b_reg, sign_b_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic [31:0]   ua_reg, ua_next;
  logic [31:0]   ub_reg, ub_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          dz_reg, dz_next;
  logic          mi_reg, mi_next;
  logic          di_reg, di_next;

  logic          sa_in, sb_in;
  logic [63:0]   prod;

  // Unsigned ops (op_sel[0]=1) are treated as having positive operands throughout.
  assign sa_in = ~op_sel[0] & value_A[31];
  assign sb_in = ~op_sel[0] & value_B[31];
  assign prod  = {mult_hi, mult_lo};

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    div_next    = div_reg;
    sign_a_next = sign_a_reg;
    sign_b_next = sign_b_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    ua_next     = ua_reg;
    ub_next     = ub_reg;
    done_next   = 1'b0;
    dz_next     = 1'b0;
    mi_next     = 1'b0;
    di_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (mthi) hi_next = wr_data;
        if (mtlo) lo_next = wr_data;
        if (op_start) begin
          if (op_sel[1] && (value_B == 32'd0)) begin
            done_next = 1'b1;
            dz_next   = 1'b1;
          end else begin
            div_next    = op_sel[1];
            sign_a_next = sa_in;
            sign_b_next = sb_in;
            ua_next     = sa_in ? (~value_A + 32'd1) : value_A;
            ub_next     = sb_in ? (~value_B + 32'd1) : value_B;
            mi_next     = ~op_sel[1];
            di_next     = op_sel[1];
            state_next  = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        cnt_next   = div_reg ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = FIXUP;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      FIXUP: begin
        if (div_reg) begin
          lo_next = (sign_a_reg ^ sign_b_reg) ? (~div_q + 32'd1) : div_q;
          hi_next = sign_a_reg ? (~div_r + 32'd1) : div_r;
        end else if (sign_a_reg ^ sign_b_reg) begin
          {hi_next, lo_next} = ~prod + 64'd1;
        end else begin
          {hi_next, lo_next} = prod;
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

`ifdef MULDIV_ABORT_EN
    // Flush: discard the in-flight result entirely.
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      done_next  = 1'b0;
    end
`endif

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      div_reg    <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      ua_reg     <= '0;
      ub_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dz_reg     <= 1'b0;
      mi_reg     <= 1'b0;
      di_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      div_reg    <= div_next;
      sign_a_reg <= sign_a_next;
      sign_b_reg <= sign_b_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      ua_reg     <= ua_next;
      ub_reg     <= ub_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      dz_reg     <= dz_next;
      mi_reg     <= mi_next;
      di_reg     <= di_next;
    end
  end

`ifdef MULDIV_ABORT_EN
  assign mult_init = mi_reg & ~abort;
  assign div_init  = di_reg & ~abort;
`else
  assign mult_init = mi_reg;
  assign div_init  = di_reg;
`endif
  assign unit_A   = ua_reg;
  assign unit_B   = ub_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = dz_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops push expected HI/LO and done cycle; a monitor
// pops and compares on every done pulse. Behavioural mult/div units hang off unit_A/unit_B.
module tb_muldiv_ctrl;
  localparam int MC = 33;
  localparam int DC = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_start, mthi, mtlo;
  logic [1:0]  op_sel;
  logic [31:0] value_A, value_B, wr_data;
  logic        mult_init, div_init, busy, done, div_zero;
  logic [31:0] unit_A, unit_B, mult_hi, mult_lo, div_q, div_r, hi, lo;
`ifdef MULDIV_ABORT_EN
  logic        abort;
`endif

  typedef struct {int cyc; logic dz; logic [31:0] hi; logic [31:0] lo;} exp_t;
  exp_t sbq[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(rst), .op_start(op_start), .op_sel(op_sel),
    .value_A(value_A), .value_B(value_B), .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
`ifdef MULDIV_ABORT_EN
    .abort(abort),
`endif
    .mult_init(mult_init), .div_init(div_init), .unit_A(unit_A), .unit_B(unit_B),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_q(div_q), .div_r(div_r),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Raw unsigned units; results are stable long before FIXUP samples them.
  assign {mult_hi, mult_lo} = {32'd0, unit_A} * {32'd0, unit_B};
  assign div_q = (unit_B != 0) ? unit_A / unit_B : 32'd0;
  assign div_r = (unit_B != 0) ? unit_A % unit_B : 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        $display("op done cycle=%0d dz=%0b hi=%h lo=%h", cyc, div_zero, hi, lo);
      end
    end
  end

  // Called at a negedge; op_start is sampled on the following posedge.
  task automatic run_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eua, input logic [31:0] eub,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input bit dz, input bit intrude);
    exp_t e;
    int lat;
    bit isdiv;
    logic [31:0] lo_before;
    isdiv = sel[1];
    lat = dz ? 1 : ((isdiv ? DC : MC) + 3);
    e.cyc = cyc + lat; e.dz = dz; e.hi = ehi; e.lo = elo;
    sbq.push_back(e);
    lo_before = lo;
    op_start = 1'b1; op_sel = sel; value_A = a; value_B = b;
    @(posedge clk); #1;
    op_start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("busy", 64'(busy), 64'(!dz && c < lat));
      chk("mult_init", 64'(mult_init), 64'(!dz && !isdiv && c == 1));
      chk("div_init", 64'(div_init), 64'(!dz && isdiv && c == 1));
      if (c == 1 && !dz) begin
        chk("unit_A", 64'(unit_A), 64'(eua));
        chk("unit_B", 64'(unit_B), 64'(eub));
      end
      if (intrude && c == 5) begin
        mtlo = 1'b1; wr_data = 32'hDEAD_BEEF;
        op_start = 1'b1; op_sel = 2'b11; value_A = 32'd9; value_B = 32'd0;
      end
      if (intrude && c == 6) begin
        chk("mtlo_busy", 64'(lo), 64'(lo_before));
        mtlo = 1'b0; op_start = 1'b0;
      end
    end
    #1;
    chk("done_seen", 64'(sbq.size()), 64'd0);
    if (sbq.size() != 0) void'(sbq.pop_front());
  endtask

  initial begin
    rst = 1'b1; op_start = 1'b0; op_sel = 2'b00; value_A = '0; value_B = '0;
    mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
`ifdef MULDIV_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_unit_A", 64'(unit_A), 64'd0);
    rst = 1'b0;

    // Back-to-back: each new op is issued in the previous op's done cycle.
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFE, 32'd3, 32'd2, 32'hFFFF_FFFA, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2, 32'd1, 32'hFFFF_FFFD, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 32'd1, 0, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'd0, 0, 0);
    run_op(2'b11, 32'd5, 32'd0, 32'd0, 32'd0, 32'h4000_0000, 32'd0, 1, 0);
    @(negedge clk);
    chk("dz_one_cycle", 64'(div_zero), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);

    mthi = 1'b1; wr_data = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo_kept", 64'(lo), 64'd0);

    run_op(2'b01, 32'd3, 32'd4, 32'd3, 32'd4, 32'd0, 32'hC, 0, 1);

    // Reset mid-WAIT: the pending op must vanish without a done pulse.
    op_start = 1'b1; op_sel = 2'b00; value_A = 32'd3; value_B = 32'd4;
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("wait_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_unit_A", 64'(unit_A), 64'd0);
    repeat (MC + 6) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h0000_55AA;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", 64'(hi), 64'h55AA);
    chk("mtboth_lo", 64'(lo), 64'h55AA);

`ifdef MULDIV_ABORT_EN
    op_start = 1'b1; op_sel = 2'b00; value_A = 32'd3; value_B = 32'd4;
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'h55AA);
    chk("abort_lo", 64'(lo), 64'h55AA);
    repeat (MC + 6) @(negedge clk);
    chk("post_abort_lo", 64'(lo), 64'h55AA);
`endif

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the shared iterative multiply and divide units in the multicycle CPU datapath. Accepts MULT/MULTU/DIV/DIVU requests from the main control unit and converts signed operands to magnitudes. Pulses the unit's init, waits the fixed iteration count, then sign-corrects the raw results and owns the architectural HI/LO registers. Also services MTHI/MTLO, raises busy for the control-unit stall, and flags divide-by-zero.

Parameters:
MULT_CYCLES, 33, cycles the multiply unit needs from init pulse to valid result (>=1)
DIV_CYCLES, 33, cycles the divide unit needs from init pulse to valid result (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
op_start  in  1  request pulse, sampled only in IDLE
op_sel  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
value_A  in  32  rs operand
value_B  in  32  rt operand
mthi  in  1  write wr_data to HI
mtlo  in  1  write wr_data to LO
wr_data  in  32  MTHI/MTLO data
mult_init  out  1  one-cycle start to multiply unit
div_init  out  1  one-cycle start to divide unit
unit_A  out  32  registered operand magnitude A to both units
unit_B  out  32  registered operand magnitude B to both units
mult_hi  in  32  raw unsigned product [63:32]
mult_lo  in  32  raw unsigned product [31:0]
div_q  in  32  raw unsigned quotient
div_r  in  32  raw unsigned remainder
busy  out  1  operation in progress, CPU stalls
done  out  1  one-cycle completion pulse
div_zero  out  1  one-cycle divide-by-zero flag
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- All outputs, state, counter, latched op/sign bits are registered. Reset (synchronous, any state, including mid-operation) forces:
  - state IDLE;
  - hi, lo, unit_A, unit_B, counter = 0;
  - busy, done, div_zero, mult_init, div_init = 0.
- States: IDLE, LAUNCH, WAIT, FIXUP.
- IDLE with op_start=1 and op_sel a DIV/DIVU with value_B=0:
  - no launch, stay IDLE, HI/LO unchanged;
  - next cycle done=1 and div_zero=1 for one cycle.
- IDLE with op_start=1, any other case:
  - Latch op_sel, sign_A=value_A[31], sign_B=value_B[31].
  - Signed ops: unit_A/unit_B = two's-complement magnitude. Unsigned ops: raw values.
  - Magnitude of 0x80000000 is 0x80000000.
  - Go to LAUNCH.
- LAUNCH (1 cycle):
  - mult_init=1 for multiplies, div_init=1 for divides. Never both, never longer than one cycle.
  - Load counter with CYCLES-1; go to WAIT.
- WAIT: decrement counter each cycle. In the cycle the counter is 0, go to FIXUP (WAIT lasts exactly CYCLES cycles).
- FIXUP (1 cycle): write HI/LO, go to IDLE, set done=1 for the following cycle.
  - MULT: if sign_A^sign_B, negate the 64-bit {mult_hi,mult_lo}.
  - DIV: quotient negated if sign_A^sign_B; remainder negated if sign_A.
  - Mapping: multiply HI=product[63:32], LO=product[31:0]; divide HI=remainder, LO=quotient.
  - Overflow case 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
- busy=1 in LAUNCH, WAIT and FIXUP, 0 in IDLE.
- Latency from op_start in cycle 0:
  - mult_init/div_init in cycle 1;
  - done and new HI/LO visible in cycle CYCLES+3;
  - busy high in cycles 1..CYCLES+2.
- A new op_start is accepted in the done cycle.
- op_start while busy: ignored, no queuing.
- mthi/mtlo:
  - In IDLE: update the register next cycle. Both high updates both.
  - Together with op_start in IDLE: the write is applied and the operation proceeds; the operation's FIXUP later overwrites.
  - While busy: ignored.
- unit_A/unit_B hold their values until the next accepted op.

Optional Feature:
MULDIV_ABORT_EN:
- Defined: adds input port abort (1 bit).
  - abort=1 in LAUNCH/WAIT/FIXUP returns to IDLE next cycle.
  - No HI/LO write, no done; busy=0 next cycle.
  - init pulses suppressed in that cycle.
  - abort in IDLE has no effect.
  - Used for exception flush.
- Undefined: no abort port; operations always run to completion.

Test Plan:
1. MULT A=0xFFFFFFFE B=0x00000003, start at cycle 0 (CYCLES=33) -> unit_A=2; mult_init only in cycle 1; busy cycles 1..35; done cycle 36; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. MULTU A=0xFFFFFFFE B=3 -> HI=0x00000002, LO=0xFFFFFFFA.
3. DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU A=5 B=0 -> done=div_zero=1 in cycle 1 only; div_init never asserted; HI/LO unchanged.
5. MTHI 0x1234 in IDLE -> hi=0x1234 next cycle. Start MULTU 3*4, then MTLO and second op_start while busy -> both ignored; HI=0, LO=0xC.
6. Reset asserted during WAIT -> next cycle IDLE, hi=lo=0, busy=0, no done. With MULDIV_ABORT_EN, abort in WAIT -> IDLE, HI/LO keep prior values.
